// File: rtl/arb_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding and default widths.
package arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage : arb_pkg

// File: rtl/adder_arbiter_adder.sv
// Shared combinational adder; the result carries the full carry-out bit.
module adder_arbiter_adder #(
  parameter int DATA_W = arb_pkg::DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule : adder_arbiter_adder

// File: rtl/adder_arbiter.sv
// One adder shared round-robin among NUM_REQ requesters, one operation in flight:
// IDLE grants and captures operands, EXEC registers the sum, RESP holds it until taken.
module adder_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [DATA_W:0]            resp_sum,
  input  logic                       resp_ready,
  output logic                       busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W:0]     sum_q, sum_d;
  logic [DATA_W:0]     adder_sum;
  logic [ID_W-1:0]     grant;

  // Scan offsets from the far end down so the lowest offset from ptr wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_REQ;
      if (valid[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  adder_arbiter_adder #(
    .DATA_W (DATA_W)
  ) u_adder (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (adder_sum)
  );

  assign grant = rr_pick(req_valid, rr_ptr_q);

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    req_ready = '0;

    unique case (state_q)
      IDLE: begin
        // The strobe is masked while reset is held so nothing looks accepted.
        if (|req_valid && !rst) begin
          req_ready[grant] = 1'b1;
          a_d              = req_a[grant*DATA_W +: DATA_W];
          b_d              = req_b[grant*DATA_W +: DATA_W];
          id_d             = grant;
          rr_ptr_d         = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state_d          = EXEC;
        end
      end
      EXEC: begin
        sum_d   = adder_sum;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign busy       = (state_q != IDLE);

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter at NUM_REQ=4, DATA_W=8.
module tb_adder_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [8:0]  resp_sum;
  logic        resp_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  adder_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    tick();
    tick();

    // Reset state, with requests present that must not be strobed.
    req_valid = 4'b1111;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    check("rst_resp_sum", 32'(resp_sum), 32'h0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();

    // Single request: accept in N, response in N+2.
    req_valid = 4'b0001;
    req_a     = {8'd0, 8'd0, 8'd0, 8'd3};
    req_b     = {8'd0, 8'd0, 8'd0, 8'd4};
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    check("single_nvalid_n", 32'(resp_valid), 32'h0);
    tick();
    req_valid = '0;
    #1;
    check("single_busy_exec", 32'(busy), 32'h1);
    check("single_ready_exec", 32'(req_ready), 32'h0);
    check("single_nvalid_n1", 32'(resp_valid), 32'h0);
    tick();
    check("single_valid_n2", 32'(resp_valid), 32'h1);
    check("single_id", 32'(resp_id), 32'h0);
    check("single_sum", 32'(resp_sum), 32'd7);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("single_idle_valid", 32'(resp_valid), 32'h0);
    check("single_idle_busy", 32'(busy), 32'h0);

    // Carry: 255+255 on requester 2.
    req_valid = 4'b0100;
    req_a     = {8'd0, 8'd255, 8'd0, 8'd0};
    req_b     = {8'd0, 8'd255, 8'd0, 8'd0};
    #1;
    check("carry_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    check("carry_valid", 32'(resp_valid), 32'h1);
    check("carry_id", 32'(resp_id), 32'h2);
    check("carry_sum", 32'(resp_sum), 32'h1FE);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Wrap-around: pointer now 3, requesters 0 and 2 valid.
    req_valid = 4'b0101;
    req_a     = {8'd0, 8'd100, 8'd0, 8'd5};
    req_b     = {8'd0, 8'd50, 8'd0, 8'd6};
    #1;
    check("wrap_ready0", 32'(req_ready), 32'h1);
    tick();
    tick();
    check("wrap_id0", 32'(resp_id), 32'h0);
    check("wrap_sum0", 32'(resp_sum), 32'd11);
    resp_ready = 1'b1;
    tick();
    check("wrap_ready2", 32'(req_ready), 32'h4);
    tick();
    tick();
    check("wrap_id2", 32'(resp_id), 32'h2);
    check("wrap_sum2", 32'(resp_sum), 32'd150);
    tick();
    resp_ready = 1'b0;
    req_valid  = '0;

    // Backpressure: requester 1 granted, response held for 5 cycles.
    req_valid = 4'b0010;
    req_a     = {8'd0, 8'd0, 8'd200, 8'd0};
    req_b     = {8'd0, 8'd0, 8'd100, 8'd0};
    #1;
    check("bp_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(resp_valid), 32'h1);
      check("bp_id", 32'(resp_id), 32'h1);
      check("bp_sum", 32'(resp_sum), 32'h12C);
      check("bp_ready_held", 32'(req_ready), 32'h0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("bp_resume_ready", 32'(req_ready), 32'h4);
    check("bp_resume_valid", 32'(resp_valid), 32'h0);
    req_valid  = '0;
    resp_ready = 1'b0;
    tick();
    check("drop_no_change", 32'(busy), 32'h0);

    // Mid-operation reset while in EXEC.
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1000;
    check("mid_busy_exec", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_busy_rst", 32'(busy), 32'h0);
    check("mid_valid_rst", 32'(resp_valid), 32'h0);
    check("mid_ready_rst", 32'(req_ready), 32'h0);
    tick();
    rst       = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_resp", 32'(resp_valid), 32'h0);
    end

    // Fairness: all valid, consumer always ready; grants restart at 0.
    req_valid  = 4'b1111;
    req_a      = {8'd40, 8'd30, 8'd20, 8'd10};
    req_b      = {8'd4, 8'd3, 8'd2, 8'd1};
    resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      check("fair_onehot_exec", 32'($onehot0(req_ready)), 32'h1);
      tick();
      check("fair_onehot_resp", 32'($onehot0(req_ready)), 32'h1);
      check("fair_id", 32'(resp_id), 32'(k % 4));
      check("fair_sum", 32'(resp_sum), 32'(11 * ((k % 4) + 1)));
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_adder_arbiter
